hex_scan_ctrl: RTL and testbench
================================

# hex_scan_ctrl

Sequencer that shares one combinational hex-to-seven-segment decoder among NUM_DIGITS display digits. On a load request it captures a multi-nibble value, presents each nibble to the shared decoder in turn (most significant first), and latches the decoded active-low segment pattern into a per-digit output register. Optional leading-zero blanking is applied. It sits between the value source (switches or a counter) and the HEX display pins.

## Interface
- NUM_DIGITS, default 6: number of display digits scanned; legal range 1..8.
- clock  in  1  system clock; all state changes on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- value  in  4*NUM_DIGITS  digit i is value[4i+3:4i]; digit 0 is least significant; sampled only on an accepted load.
- load  in  1  start request; accepted only in IDLE.
- blank_lz  in  1  leading-zero blanking enable; sampled with value on an accepted load.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when all digits have been written.
- dec_nibble  out  4  nibble presented to the shared decoder.
- dec_seg  in  7  active-low segments from the shared decoder, combinational from dec_nibble in the same cycle; bit 0 = segment a … bit 6 = segment g.
- hex_out  out  7*NUM_DIGITS  registered segments; digit i is hex_out[7i+6:7i]; 7'h7F = blank.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: dec_nibble = 0. If load=1: capture value into a shadow register, capture blank_lz, set idx = NUM_DIGITS-1, set lead flag = 1, go to SCAN.
- SCAN: dec_nibble = shadow[idx]. On each clock edge, write digit idx of hex_out:
  - 7'h7F if blanking is captured, lead=1, nibble=0, and idx≠0;
  - otherwise dec_seg, and clear lead.
  - If idx=0, go to DONE; else decrement idx.
- DONE: done=1 for this cycle only. Go to IDLE.
- Digits not yet rewritten in a scan keep their previous contents. Partial update during a scan is permitted.
- Digit 0 is never blanked, so the value 0 shows "0".
- load while busy (SCAN or DONE) is ignored; it is neither queued nor does it alter the shadow register.
- Changes on value or blank_lz after acceptance have no effect on the current scan.
- idx register width is clog2(NUM_DIGITS), minimum 1 bit. idx never wraps below 0.

## Timing
- Reset values: state IDLE, hex_out all 7'h7F, busy 0, done 0, dec_nibble 0, idx 0, lead 0, shadow 0.
- Cycle numbering, with load accepted at edge t:
  - busy=1 from t through t+N+1.
  - Digit N-1 is written at edge t+1, …, digit 0 at edge t+N.
  - done=1 during the cycle after edge t+N (state DONE).
  - IDLE is re-entered at edge t+N+1.
- The earliest next load is accepted at edge t+N+2.
- Total latency from load to done: N+1 cycles. For NUM_DIGITS=6, done is high in cycle 7 after load.
- Reset asserted mid-scan aborts the scan at that edge: all digits are blanked and no done pulse is produced.
- resetn=0 and load=1 on the same edge: reset wins and the load is dropped.
- load held high continuously: a new scan starts each time IDLE is reached, i.e. every N+2 cycles.

## Test plan
- Bench model of the decoder: 0→7'h40, 1→7'h79, 2→7'h24, 8→7'h00, A→7'h08, F→7'h0E.
- Reset: hold resetn=0 for 2 cycles -> hex_out=42'h3FF_FFFF_FFFF (all 7'h7F), busy=0, done=0, dec_nibble=0.
- Basic scan, NUM_DIGITS=6, value=24'h12A8F0, blank_lz=0, 1-cycle load ->
  - dec_nibble sequence is 1,2,A,8,F,0 on consecutive cycles;
  - final digits 5..0 = 7'h79, 24, 08, 00, 0E, 40;
  - done pulses exactly once, 7 cycles after load; busy low 8 cycles after load.
- Leading-zero blanking: value=24'h000801, blank_lz=1 ->
  - digits 5,4,3 = 7'h7F; digit 2 = 7'h00; digit 1 = 7'h40 (interior zero not blanked); digit 0 = 7'h79.
  - value=0, blank_lz=1 -> digits 5..1 blank, digit 0 = 7'h40.
- Load while busy: pulse load again 3 cycles into a scan with a different value -> ignored; result matches the first value; a single done pulse.
- Reset mid-scan: deassert resetn at cycle 3 of a scan -> next edge all digits 7'h7F, busy=0, no done pulse. A subsequent load completes normally.
- Continuous load=1 with value toggled between two patterns -> done every 8 cycles; each scan reflects the value present at its own acceptance edge.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - scans a multi-nibble value through one shared hex-to-7seg decoder
module hex_scan_ctrl #(
  parameter int NUM_DIGITS = 6
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      load,
  input  logic                      blank_lz,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                dec_nibble,
  input  logic [6:0]                dec_seg,
  output logic [7*NUM_DIGITS-1:0]   hex_out
);

  localparam int               IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = '0;
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      lead_q, lead_d;
  logic                      blank_q, blank_d;
  logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
  logic [7*NUM_DIGITS-1:0]   hex_q, hex_d;

  logic [3:0]                cur_nibble;
  logic                      blank_now;
  logic [6:0]                seg_wr;

  // Pick the shadow nibble addressed by the scan index
  always_comb begin
    cur_nibble = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nibble = shadow_q[4*i +: 4];
      end
    end
  end

  // Leading zeros are blanked only while no nonzero digit has been seen; digit 0 always shows
  always_comb begin
    blank_now = blank_q && lead_q && (cur_nibble == 4'h0) && (idx_q != IDX_ZERO);
    seg_wr    = blank_now ? SEG_BLANK : dec_seg;
  end

  // Next-state and output logic for the scan sequencer
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lead_d     = lead_q;
    blank_d    = blank_q;
    shadow_d   = shadow_q;
    hex_d      = hex_q;
    dec_nibble = 4'h0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (load) begin
          shadow_d = value;
          blank_d  = blank_lz;
          idx_d    = IDX_TOP;
          lead_d   = 1'b1;
          state_d  = S_SCAN;
        end
      end

      S_SCAN: begin
        dec_nibble = cur_nibble;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            hex_d[7*i +: 7] = seg_wr;
          end
        end
        if (!blank_now) begin
          lead_d = 1'b0;
        end
        if (idx_q == IDX_ZERO) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any scan and blanks every digit
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      lead_q   <= 1'b0;
      blank_q  <= 1'b0;
      shadow_q <= '0;
      hex_q    <= '1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lead_q   <= lead_d;
      blank_q  <= blank_d;
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
    end
  end

  assign hex_out = hex_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - directed self-checking bench for hex_scan_ctrl
module tb_hex_scan_ctrl;

  localparam int N = 6;

  logic            clock;
  logic            resetn;
  logic [4*N-1:0]  value;
  logic            load;
  logic            blank_lz;
  logic            busy;
  logic            done;
  logic [3:0]      dec_nibble;
  logic [6:0]      dec_seg;
  logic [7*N-1:0]  hex_out;

  int n_cmp = 0;
  int n_err = 0;
  int n_done;

  hex_scan_ctrl #(.NUM_DIGITS(N)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .busy       (busy),
    .done       (done),
    .dec_nibble (dec_nibble),
    .dec_seg    (dec_seg),
    .hex_out    (hex_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference active-low hex decoder (bit0 = a ... bit6 = g)
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;
      4'h2: seg_of = 7'h24;  4'h3: seg_of = 7'h30;
      4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;
      4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;
      4'h8: seg_of = 7'h00;  4'h9: seg_of = 7'h10;
      4'hA: seg_of = 7'h08;  4'hB: seg_of = 7'h03;
      4'hC: seg_of = 7'h46;  4'hD: seg_of = 7'h21;
      4'hE: seg_of = 7'h06;  default: seg_of = 7'h0E;
    endcase
  endfunction

  assign dec_seg = seg_of(dec_nibble);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam logic [7*N-1:0] HEX_ALL_BLANK = 42'h3FF_FFFF_FFFF;
  localparam logic [7*N-1:0] HEX_12A8F0    = {7'h79, 7'h24, 7'h08, 7'h00, 7'h0E, 7'h40};
  localparam logic [7*N-1:0] HEX_000801_LZ = {7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h40, 7'h79};
  localparam logic [7*N-1:0] HEX_000000_LZ = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [7*N-1:0] HEX_000801    = {7'h40, 7'h40, 7'h40, 7'h00, 7'h40, 7'h79};
  localparam logic [7*N-1:0] HEX_012345    = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

  logic [3:0] exp_nib [6];

  initial begin
    exp_nib = '{4'h1, 4'h2, 4'hA, 4'h8, 4'hF, 4'h0};

    // Reset held for two edges
    resetn = 1'b0; load = 1'b0; value = '0; blank_lz = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_hex", hex_out, HEX_ALL_BLANK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nib", dec_nibble, 4'h0);
    resetn = 1'b1;
    @(negedge clock);
    chk("idle_hex", hex_out, HEX_ALL_BLANK);

    // Basic scan: nibble order, done timing, final digits
    value = 24'h12A8F0; blank_lz = 1'b0; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("basic_nib%0d", k), dec_nibble, exp_nib[k]);
      chk($sformatf("basic_busy%0d", k), busy, 1'b1);
      chk($sformatf("basic_nodone%0d", k), done, 1'b0);
      @(negedge clock);
    end
    chk("basic_done", done, 1'b1);
    chk("basic_busy_done", busy, 1'b1);
    @(negedge clock);
    chk("basic_done_off", done, 1'b0);
    chk("basic_busy_off", busy, 1'b0);
    chk("basic_hex", hex_out, HEX_12A8F0);
    chk("basic_idle_nib", dec_nibble, 4'h0);

    // Leading-zero blanking with an interior zero
    value = 24'h000801; blank_lz = 1'b1; load = 1'b1;
    @(negedge clock);
    load = 1'b0; value = 24'hFFFFFF; blank_lz = 1'b0;
    repeat (7) @(negedge clock);
    chk("lz_hex", hex_out, HEX_000801_LZ);
    chk("lz_busy", busy, 1'b0);

    // All-zero value with blanking keeps digit 0 visible
    value = 24'h000000; blank_lz = 1'b1; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (7) @(negedge clock);
    chk("zero_hex", hex_out, HEX_000000_LZ);

    // Load while busy is ignored and yields one done pulse
    value = 24'h012345; blank_lz = 1'b0; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done) n_done++;
      if (c == 3) begin value = 24'hFFFFFF; load = 1'b1; end
      if (c == 4) load = 1'b0;
      @(negedge clock);
    end
    chk("busyload_hex", hex_out, HEX_012345);
    chk("busyload_ndone", n_done, 1);

    // Reset mid-scan, with load asserted on the same edge
    value = 24'h12A8F0; blank_lz = 1'b0; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b0; load = 1'b1;
    @(negedge clock);
    chk("midrst_hex", hex_out, HEX_ALL_BLANK);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    resetn = 1'b1; load = 1'b0;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) n_done++;
      @(negedge clock);
    end
    chk("midrst_nodone", n_done, 0);
    chk("midrst_still_blank", hex_out, HEX_ALL_BLANK);

    // Scan after reset completes normally
    value = 24'h12A8F0; blank_lz = 1'b0; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (7) @(negedge clock);
    chk("postrst_hex", hex_out, HEX_12A8F0);

    // Continuous load: a scan every N+2 cycles, each using the value at its own acceptance
    value = 24'h12A8F0; blank_lz = 1'b0; load = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      chk($sformatf("cont_done_c%0d", c), done, ((c % 8) == 7));
      if (c == 3)  value = 24'h000801;
      if (c == 8)  chk("cont_hex_scan1", hex_out, HEX_12A8F0);
      if (c == 11) value = 24'h12A8F0;
      if (c == 16) chk("cont_hex_scan2", hex_out, HEX_000801);
      if (c == 20) load = 1'b0;
      if (c == 24) chk("cont_hex_scan3", hex_out, HEX_12A8F0);
    end
    @(negedge clock);
    chk("cont_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
